list_summary: RTL and testbench

LIST_SUMMARY -- requirements
Module: list_summary

---
 rtl/list_summary_pkg.sv | 23 ++
 rtl/summary_fifo.sv | 54 +++++
 rtl/list_summary.sv | 108 ++++++++++
 tb/tb_list_summary.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/list_summary_pkg.sv
// Shared types for the linked-list summariser: pointer width, record layout, collector states.
package list_summary_pkg;

  localparam int n     = 16;
  localparam int Width = $clog2(n);
  localparam int LenW  = Width + 1;

  typedef logic [Width-1:0] Pointer;

  typedef struct packed {
    Pointer            head;
    Pointer            tail;
    logic [LenW-1:0]   len;
    Pointer            csum;
    logic              loop;
  } ListSummary;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/summary_fifo.sv
// Depth-entry FIFO of ListSummary records; push_rdy stays high when full if a pop frees a slot the same cycle.
// Head record is visible combinationally on pop_dat and reads as zero while empty.
module summary_fifo
  import list_summary_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_vld,
  input  ListSummary push_dat,
  output logic       push_rdy,
  output logic       pop_vld,
  output ListSummary pop_dat,
  input  logic       pop_rdy
);

  localparam int AW = $clog2(Depth);

  ListSummary     mem [Depth];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push;
  logic           pop;

  assign pop_vld  = (count != '0);
  assign pop      = pop_vld && pop_rdy;
  assign push_rdy = (count != (AW+1)'(Depth)) || pop;
  assign push     = push_vld && push_rdy;
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/list_summary.sv
// Collects runs of non-null pointers into {head,tail,len,csum,loop} records and queues them for the consumer.
// Records drop (counted, sticky overflow) when the queue is full and not draining.
module list_summary
  import list_summary_pkg::*;
#(
  parameter int n     = list_summary_pkg::n,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in_ptr,
  input  logic             in_ptr_vld,
  output logic [Width-1:0] out_head,
  output logic [Width-1:0] out_tail,
  output logic [LenW-1:0]  out_len,
  output logic [Width-1:0] out_csum,
  output logic             out_loop,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  state_t          state;
  Pointer          head;
  Pointer          tail;
  Pointer          csum;
  logic [LenW-1:0] len;
  logic            loop;

  logic       elem;
  logic       push_vld;
  logic       push_rdy;
  ListSummary push_dat;
  ListSummary pop_dat;

  // A null pointer counts as a gap even when flagged valid.
  assign elem     = in_ptr_vld && (in_ptr != '0);
  assign push_vld = (state == COLLECT) && !elem;
  assign push_dat = '{head: head, tail: tail, len: len, csum: csum, loop: loop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      csum  <= '0;
      len   <= '0;
      loop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elem) begin
            head  <= in_ptr;
            tail  <= in_ptr;
            csum  <= in_ptr;
            len   <= LenW'(1);
            loop  <= 1'b0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (elem) begin
            tail <= in_ptr;
            csum <= csum ^ in_ptr;
            // Length pins at n; hitting it marks the list as a suspected cycle.
            if (len != LenW'(n)) begin
              len <= len + 1'b1;
              if (len == LenW'(n - 1)) loop <= 1'b1;
            end
          end else begin
            loop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (push_vld && !push_rdy) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  summary_fifo #(.Depth(Depth)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .pop_vld  (out_vld),
    .pop_dat  (pop_dat),
    .pop_rdy  (out_rdy)
  );

  assign out_head = pop_dat.head;
  assign out_tail = pop_dat.tail;
  assign out_len  = pop_dat.len;
  assign out_csum = pop_dat.csum;
  assign out_loop = pop_dat.loop;

endmodule

// File: tb/tb_list_summary.sv
// Directed scenarios plus a randomized run against a queue-based list/FIFO model.
module tb_list_summary;
  import list_summary_pkg::*;

  localparam int Depth = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [Width-1:0] in_ptr = '0;
  logic             in_ptr_vld = 1'b0;
  logic [Width-1:0] out_head;
  logic [Width-1:0] out_tail;
  logic [LenW-1:0]  out_len;
  logic [Width-1:0] out_csum;
  logic             out_loop;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int checks   = 0;
  int failures = 0;

  list_summary #(.n(16), .Depth(Depth)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_ptr     (in_ptr),
    .in_ptr_vld (in_ptr_vld),
    .out_head   (out_head),
    .out_tail   (out_tail),
    .out_len    (out_len),
    .out_csum   (out_csum),
    .out_loop   (out_loop),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic ListSummary mk(input int h, input int t, input int l, input int c, input int lp);
    ListSummary r;
    r.head = Pointer'(h);
    r.tail = Pointer'(t);
    r.len  = LenW'(l);
    r.csum = Pointer'(c);
    r.loop = lp[0];
    return r;
  endfunction

  function automatic ListSummary dut_rec();
    return ListSummary'({out_head, out_tail, out_len, out_csum, out_loop});
  endfunction

  // Inputs change on the falling edge; each call covers exactly one rising edge.
  task automatic step(input logic v, input int p);
    in_ptr_vld = v;
    in_ptr     = Pointer'(p);
    @(negedge clk);
  endtask

  task automatic pop_record(output logic ok, output ListSummary rec);
    ok = 1'b0;
    rec = '0;
    in_ptr_vld = 1'b0;
    in_ptr = '0;
    out_rdy = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_vld) begin
        rec = dut_rec();
        ok = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_ptr_vld = 1'b0;
    in_ptr = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_vld, out_head, out_tail, out_len, out_csum, out_loop, overflow, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%0b rec=%h ovf=%0b drops=%0d want all zero",
               out_vld, dut_rec(), overflow, drop_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    ListSummary exp;
    exp = mk(1, 10, 4, 13, 0);
    out_rdy = 1'b1;
    step(1, 1); step(1, 5); step(1, 3); step(1, 10);
    checks++;
    if (out_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_no_early_vld got=%0b want=0", out_vld);
    end
    step(0, 0);
    checks++;
    if (out_vld !== 1'b1 || dut_rec() !== exp) begin
      failures++;
      $display("FAIL basic_record got vld=%0b rec=%h want vld=1 rec=%h", out_vld, dut_rec(), exp);
    end
    step(0, 0);
    checks++;
    if (out_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_drained got vld=%0b want=0", out_vld);
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_two_lists();
    ListSummary exp [2];
    ListSummary r;
    logic ok;
    exp[0] = mk(7, 8, 3, 0, 0);
    exp[1] = mk(9, 12, 5, 13, 0);
    step(1, 7); step(1, 15); step(1, 8); step(0, 0);
    step(1, 9); step(1, 14); step(1, 11); step(1, 13); step(1, 12); step(0, 0);
    for (int i = 0; i < 2; i++) begin
      pop_record(ok, r);
      checks++;
      if (!ok || r !== exp[i]) begin
        failures++;
        $display("FAIL two_lists_rec%0d got ok=%0b rec=%h want rec=%h", i, ok, r, exp[i]);
      end
    end
  endtask

  task automatic test_null_gaps();
    ListSummary exp [2];
    ListSummary r;
    logic ok;
    exp[0] = mk(2, 2, 1, 2, 0);
    exp[1] = mk(4, 4, 1, 4, 0);
    step(1, 2); step(1, 0); step(1, 0); step(1, 4); step(0, 0);
    for (int i = 0; i < 2; i++) begin
      pop_record(ok, r);
      checks++;
      if (!ok || r !== exp[i]) begin
        failures++;
        $display("FAIL null_gap_rec%0d got ok=%0b rec=%h want rec=%h", i, ok, r, exp[i]);
      end
    end
    step(0, 0);
    checks++;
    if (out_vld !== 1'b0) begin
      failures++;
      $display("FAIL null_gap_extra got vld=%0b want=0", out_vld);
    end
  endtask

  task automatic test_loop();
    ListSummary exp;
    ListSummary r;
    logic ok;
    exp = mk(1, 1, 16, 1, 1);
    for (int i = 0; i < 16; i++) step(1, (i % 15) + 1);
    step(0, 0);
    pop_record(ok, r);
    checks++;
    if (!ok || r !== exp) begin
      failures++;
      $display("FAIL loop_rec got ok=%0b rec=%h want rec=%h", ok, r, exp);
    end
  endtask

  task automatic test_overflow();
    int vals [5] = '{2, 4, 6, 9, 1};
    ListSummary r;
    logic ok;
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, vals[i]);
      step(0, 0);
    end
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL overflow_flags got ovf=%0b drops=%0d want ovf=1 drops=1", overflow, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      pop_record(ok, r);
      checks++;
      if (!ok || r !== mk(vals[i], vals[i], 1, vals[i], 0)) begin
        failures++;
        $display("FAIL overflow_rec%0d got ok=%0b rec=%h want head=%0d", i, ok, r, vals[i]);
      end
    end
    step(0, 0);
    checks++;
    if (out_vld !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_after_drain got vld=%0b ovf=%0b want vld=0 ovf=1", out_vld, overflow);
    end
  endtask

  task automatic test_reset_mid();
    ListSummary exp;
    ListSummary r;
    logic ok;
    exp = mk(6, 6, 1, 6, 0);
    step(1, 1); step(1, 5);
    rst = 1'b0;
    step(1, 7);
    checks++;
    if ({out_vld, dut_rec(), overflow, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got vld=%0b rec=%h ovf=%0b drops=%0d want all zero",
               out_vld, dut_rec(), overflow, drop_cnt);
    end
    rst = 1'b1;
    step(1, 6); step(0, 0);
    pop_record(ok, r);
    checks++;
    if (!ok || r !== exp) begin
      failures++;
      $display("FAIL reset_mid_rec got ok=%0b rec=%h want rec=%h", ok, r, exp);
    end
    step(0, 0);
    checks++;
    if (out_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_extra got vld=%0b want=0", out_vld);
    end
  endtask

  task automatic test_random();
    ListSummary mq [$];
    int         cur [$];
    int         mdrops;
    logic       movf;
    ListSummary rec;
    logic       v;
    int         p;
    int         x;
    logic       fld_bad;
    do_reset();
    mdrops = 0;
    movf = 1'b0;
    fld_bad = 1'b0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if ((cyc / 200) % 2 == 1) begin
        v = ($urandom % 20) != 0;
        out_rdy = ($urandom % 8) == 0;
      end else begin
        v = ($urandom % 3) != 0;
        out_rdy = ($urandom % 3) != 0;
      end
      p = v ? $urandom_range(1, 15) : $urandom_range(0, 15);
      if (!v && ($urandom % 2 == 0)) begin
        v = 1'b1;
        p = 0;
      end
      // Model the edge: consumer takes the head, then the closing gap offers a record.
      if (mq.size() != 0 && out_rdy) void'(mq.pop_front());
      if (v && p != 0) begin
        cur.push_back(p);
      end else if (cur.size() != 0) begin
        x = 0;
        foreach (cur[k]) x ^= cur[k];
        rec = mk(cur[0], cur[cur.size()-1], (cur.size() > 16) ? 16 : cur.size(), x,
                 (cur.size() >= 16) ? 1 : 0);
        cur.delete();
        if (mq.size() < Depth) begin
          mq.push_back(rec);
        end else begin
          movf = 1'b1;
          if (mdrops < 255) mdrops++;
        end
      end
      step(v, p);
      checks++;
      if (out_vld !== (mq.size() != 0)) begin
        failures++;
        $display("FAIL rand_vld cyc=%0d got=%0b want=%0b", cyc, out_vld, mq.size() != 0);
      end else if (mq.size() != 0) begin
        checks++;
        if (dut_rec() !== mq[0]) begin
          failures++;
          $display("FAIL rand_rec cyc=%0d got=%h want=%h", cyc, dut_rec(), mq[0]);
        end
      end
      checks++;
      if (overflow !== movf || drop_cnt !== 8'(mdrops)) begin
        failures++;
        $display("FAIL rand_drops cyc=%0d got ovf=%0b drops=%0d want ovf=%0b drops=%0d",
                 cyc, overflow, drop_cnt, movf, mdrops);
      end
    end
    out_rdy = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_two_lists();
    test_null_gaps();
    test_loop();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
